// File: rtl/pending_slot_dispatcher.sv
// Pending-slot dispatcher: collects per-slot request pulses into a bitmap and
// issues one slot index per cycle (lowest set bit, optionally round-robin) on a
// valid/ready output register.
module pending_slot_dispatcher #(
  parameter int W           = 16,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [W-1:0]         set_mask,
  output logic [W-1:0]         pending_vec,
  output logic                 out_valid,
  output logic [$clog2(W)-1:0] out_index,
  input  logic                 out_ready
);
  localparam int IW = $clog2(W);

  // Handshake: a slot transfers on any rising edge where out_valid && out_ready.
  // While out_valid && !out_ready, out_valid and out_index stay stable.
  logic [W-1:0]  pending_q;
  logic          valid_q;
  logic [IW-1:0] index_q;
  logic [IW-1:0] rr_ptr_q;

  logic          fire;
  logic          load;
  logic [IW-1:0] sel;
  logic [IW-1:0] sel_lo;
  logic [IW-1:0] sel_hi;
  logic          hit_hi;
  logic [IW-1:0] rr_next;
  logic [W-1:0]  clr_vec;
  logic [W-1:0]  pending_next;

  assign fire = valid_q && out_ready;
  assign load = (!valid_q || fire) && (pending_q != '0);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    hit_hi = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_lo = IW'(i);
        if (ROUND_ROBIN && (IW'(i) >= rr_ptr_q)) begin
          sel_hi = IW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    sel = hit_hi ? sel_hi : sel_lo;
  end

  // Explicit compare against W-1 keeps the pointer in range for non-power-of-2 W.
  assign rr_next      = (sel == IW'(W - 1)) ? '0 : sel + 1'b1;
  assign clr_vec      = load ? (W'(1) << sel) : '0;
  assign pending_next = (pending_q & ~clr_vec) | set_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      rr_ptr_q  <= '0;
    end else if (flush) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      pending_q <= pending_next;
      if (load) begin
        index_q  <= sel;
        valid_q  <= 1'b1;
        rr_ptr_q <= rr_next;
      end else if (fire) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pending_vec = pending_q;
  assign out_valid   = valid_q;
  assign out_index   = index_q;

endmodule

// File: tb/tb_pending_slot_dispatcher.sv
// Bench for pending_slot_dispatcher: a round-robin and a fixed-priority
// instance share one stimulus and are checked against a circular-search model.
module tb_pending_slot_dispatcher;
  localparam int W  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [W-1:0]  set_mask;
  logic          out_ready;

  logic [W-1:0]  pend_rr, pend_fx;
  logic          valid_rr, valid_fx;
  logic [IW-1:0] idx_rr, idx_fx;

  int checks   = 0;
  int failures = 0;

  // model state: [0] round-robin instance, [1] fixed-priority instance
  logic [W-1:0]  m_pend [2];
  logic          m_valid[2];
  logic [IW-1:0] m_idx  [2];
  int            m_rr   [2];

  logic [IW-1:0] log_q[2][$];
  logic [IW-1:0] exp_q[$];

  pending_slot_dispatcher #(.W(W), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .set_mask(set_mask),
    .pending_vec(pend_rr), .out_valid(valid_rr), .out_index(idx_rr),
    .out_ready(out_ready)
  );

  pending_slot_dispatcher #(.W(W), .ROUND_ROBIN(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .flush(flush), .set_mask(set_mask),
    .pending_vec(pend_fx), .out_valid(valid_fx), .out_index(idx_fx),
    .out_ready(out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: circular search of the pending set from the start slot
  always @(posedge clk or negedge rst_n) begin : model
    logic          fire, load;
    logic [W-1:0]  np;
    int            sel, start, j;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_pend[m] <= '0; m_valid[m] <= 1'b0; m_idx[m] <= '0; m_rr[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        fire  = m_valid[m] && out_ready;
        load  = (!m_valid[m] || fire) && (m_pend[m] != 0);
        start = (m == 0) ? m_rr[m] : 0;
        sel   = -1;
        for (int k = 0; k < W; k++) begin
          j = (start + k) % W;
          if (sel < 0 && m_pend[m][j]) sel = j;
        end
        if (flush) begin
          m_pend[m] <= '0; m_valid[m] <= 1'b0; m_rr[m] <= 0;
        end else begin
          np = m_pend[m];
          if (load) np[sel] = 1'b0;
          m_pend[m] <= np | set_mask;
          if (load) begin
            m_idx[m]   <= sel[IW-1:0];
            m_valid[m] <= 1'b1;
            m_rr[m]    <= (sel + 1) % W;
          end else if (fire) begin
            m_valid[m] <= 1'b0;
          end
        end
      end
    end
  end

  // compare process plus dispatch log
  always @(negedge clk) begin
    cmp("rr_pending", pend_rr, m_pend[0]);
    cmp("rr_valid", valid_rr, m_valid[0]);
    if (m_valid[0]) cmp("rr_index", idx_rr, m_idx[0]);
    cmp("fx_pending", pend_fx, m_pend[1]);
    cmp("fx_valid", valid_fx, m_valid[1]);
    if (m_valid[1]) cmp("fx_index", idx_fx, m_idx[1]);
    if (rst_n && !flush && out_ready) begin
      if (valid_rr) log_q[0].push_back(idx_rr);
      if (valid_fx) log_q[1].push_back(idx_fx);
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [W-1:0] mask);
    set_mask = mask;
    tick();
    set_mask = '0;
  endtask

  // scoreboard: fired indices of instance inst against a hand-computed sequence
  task automatic check_log(input string name, input int inst, input int n,
                           input logic [IW-1:0] e0, input logic [IW-1:0] e1,
                           input logic [IW-1:0] e2, input logic [IW-1:0] e3);
    logic [IW-1:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back(e[i]);
    cmp({name, "_count"}, log_q[inst].size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q[inst].size(); i++)
      cmp($sformatf("%s_%0d", name, i), log_q[inst][i], exp_q[i]);
    log_q[inst] = {};
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; set_mask = '0; out_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    cmp("reset_pending", pend_rr, 0);
    cmp("reset_valid", valid_rr, 0);
    cmp("reset_index", idx_rr, 0);

    // idle
    out_ready = 1'b1;
    tick(10);
    cmp("idle_valid", valid_rr, 0);
    check_log("idle", 0, 0, 0, 0, 0, 0);

    // burst 16'h8421
    pulse(16'h8421);
    tick(6);
    check_log("burst_rr", 0, 4, 0, 5, 10, 15);
    check_log("burst_fx", 1, 4, 0, 5, 10, 15);
    cmp("burst_pending", pend_rr, 0);
    cmp("burst_valid", valid_rr, 0);

    // fairness: dispatch slot 5 (rr_ptr -> 6), then pending 16'h0041
    pulse(16'h0020);
    tick(3);
    pulse(16'h0041);
    tick(4);
    check_log("rr_order", 0, 3, 5, 6, 0, 0);
    check_log("fx_order", 1, 3, 5, 0, 6, 0);

    // stall with index 3 held while slot 4 is requested
    out_ready = 1'b0;
    pulse(16'h0008);
    tick();
    set_mask = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("stall_index", idx_rr, 3);
    end
    set_mask = '0;
    cmp("stall_valid", valid_rr, 1);
    cmp("stall_pending", pend_rr, 16'h0010);
    cmp("stall_fx_pending", pend_fx, 16'h0010);
    out_ready = 1'b1;
    tick();
    cmp("after_stall_index", idx_rr, 4);
    cmp("after_stall_fx_index", idx_fx, 4);
    tick(2);
    check_log("stall_rr", 0, 2, 3, 4, 0, 0);
    check_log("stall_fx", 1, 2, 3, 4, 0, 0);

    // collision: re-request slot 1 in its own load cycle
    set_mask = 16'h0002;
    tick(2);
    set_mask = '0;
    cmp("collide_index", idx_rr, 1);
    cmp("collide_valid", valid_rr, 1);
    cmp("collide_pending", pend_rr, 16'h0002);
    tick(3);
    check_log("collide_rr", 0, 2, 1, 1, 0, 0);
    check_log("collide_fx", 1, 2, 1, 1, 0, 0);

    // flush while holding a slot, with all-ones request and fire
    out_ready = 1'b0;
    pulse(16'h0101);
    tick();
    cmp("preflush_valid", valid_rr, 1);
    flush = 1'b1; set_mask = '1; out_ready = 1'b1;
    tick();
    flush = 1'b0; set_mask = '0;
    cmp("flush_pending", pend_rr, 0);
    cmp("flush_valid", valid_rr, 0);
    cmp("flush_fx_pending", pend_fx, 0);
    tick(3);
    check_log("flush_rr", 0, 0, 0, 0, 0, 0);
    check_log("flush_fx", 1, 0, 0, 0, 0, 0);

    // async reset mid-burst
    pulse('1);
    tick(3);
    #3 rst_n = 1'b0;
    #1;
    cmp("areset_valid", valid_rr, 0);
    cmp("areset_index", idx_rr, 0);
    cmp("areset_pending", pend_rr, 0);
    cmp("areset_fx_pending", pend_fx, 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    cmp("post_reset_valid", valid_rr, 0);
    check_log("areset_rr", 0, 2, 0, 1, 0, 0);
    check_log("areset_fx", 1, 2, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
